irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Parametrised interrupt controller for the chad MCU. It replaces the fixed single-source pending register and priority encoder in the MCU top level.
- Serves up to 15 sources, each selectable as edge or level, with programmable polarity, per-channel enable, software set and write-1-to-clear.
- Programmed through the CPU I/O strobes.
- Drives the processor's irq/ivec inputs and consumes iack.

Parameters:
WIDTH, 18, CPU data width; io_dout/din width.
CHANNELS, 15, number of sources, 1..min(WIDTH, 2^VBITS - 1); channel c maps to vector c (1-based).
VBITS, 4, vector width; vector 0 means "none".

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
src  in  CHANNELS  interrupt sources, already synchronous to clk; bit c-1 is channel c
io_rd  in  1  I/O read strobe for this block (pre-decoded by the parent)
io_wr  in  1  I/O write strobe for this block (pre-decoded by the parent)
io_addr  in  3  register select
din  in  WIDTH  write data
io_dout  out  WIDTH  read data
irq  out  1  interrupt request
ivec  out  VBITS  vector of the highest-priority request
iack  in  1  processor acknowledge of the current ivec

Behaviour:
Register map (bits CHANNELS-1:0 used; unused read bits are 0):
- 0 PEND: read pending; write 1s to clear.
- 1 ENA: read/write enable mask.
- 2 MODE: read/write; 1 = edge, 0 = level.
- 3 POL: read/write; 1 = active-low / falling edge.
- 4 SET: write 1s to set pending (edge channels only); reads 0.
- 5 CTRL: bit0 = global enable, read/write.
- 6 VEC: read-only, current ivec.
- 7: reads 0; writes ignored.

Reset (rst high at a clk edge):
- PEND = 0, ENA = 0, MODE = all 1s, POL = 0, CTRL = 0.
- prev <= src ^ POL_reset, so a source already high at release causes no spurious edge.
- Consequently irq = 0 and ivec = 0 while and after reset until programmed.
- Reset asserted mid-operation discards all pending state the same cycle.

Source conditioning:
- s = src ^ POL.
- prev <= s every cycle.
- Rising edge detect: e = s & ~prev.

Edge channel c, per clock; PEND[c] next state, evaluated in this priority order:
1. set if e[c], or SET write with din bit = 1;
2. otherwise cleared if PEND write with din bit = 1, or (iack and ivec == c);
3. otherwise held.
- Set wins over a clear in the same cycle, so a new edge coincident with iack or W1C is not lost.
- Latency: src edge sampled at clock k makes PEND set after edge k; irq is visible in cycle k+1.

Level channel c:
- PEND[c] <= s[c] every cycle.
- iack, W1C and SET have no effect.
- The request persists until the source deasserts or is masked.

Changing MODE or POL:
- The new value takes effect the next cycle.
- PEND for a channel switched to edge is not cleared.
- prev tracks the new s, so a POL flip can produce one edge; software clears it.

Request outputs:
- Masked channels still latch PEND.
- req = PEND & ENA, gated by CTRL.bit0.
- ivec = index of the highest set bit of req (channel 15 highest priority), 0 if none. Combinational from registers, so it updates the cycle after iack with no stale vector.
- irq = (ivec != 0).
- iack is honoured only for the channel equal to ivec in the same cycle; iack with ivec == 0 is ignored.

Register access:
- io_dout = combinational mux of io_addr; reads have no side effects.
- Writes take effect at the clk edge where io_wr is high; a write in the same cycle as iack is resolved per the priority above.
- io_rd and io_wr together: the read returns the pre-write value.

Decomposition:
- Shared package irq_pkg: register address constants (IRQ_PEND..IRQ_VEC) and the default CHANNELS/VBITS.
- One natural sub-module: the existing parametrised priority encoder prio_enc #(VBITS), instantiated on the zero-extended req vector.
- Per-channel logic stays in a generate loop in irq_ctrl.

Test Plan:
1. Reset, ENA=0x0002, CTRL=1; src[1] (channel 2) pulses 0→1 → PEND=0x0002, irq=1, ivec=2 on the next cycle; iack → PEND=0, irq=0 the following cycle.
2. ENA=0x7FFF, CTRL=1; edges on channels 3, 9 and 15 in the same cycle → ivec=15; after iack, ivec=9; after iack, ivec=3; after iack, ivec=0.
3. MODE bit 4 = 0 (level), ENA bit 4 = 1, CTRL=1, src[4] held high → ivec=5; iack → ivec stays 5; src[4] low → irq=0 next cycle.
4. Channel 1 edge in the same cycle as iack of ivec=1 (already pending) → PEND bit 0 remains 1 and irq stays high.
5. POL=0x0001 with src[0] high at reset release → no pending; src[0] falls → PEND=0x0001. Then ENA=0: read PEND=0x0001, irq=0; write PEND=0x0001 → PEND=0.
6. SET write 0x0040 with ENA=0x0040, CTRL=0 → irq=0, PEND=0x0040; CTRL=1 → ivec=7; rst asserted → PEND=0, ivec=0 the same cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map and default sizing.
package irq_pkg;

    localparam int IRQ_WIDTH    = 18;
    localparam int IRQ_CHANNELS = 15;
    localparam int IRQ_VBITS    = 4;

    localparam logic [2:0] IRQ_PEND = 3'd0;
    localparam logic [2:0] IRQ_ENA  = 3'd1;
    localparam logic [2:0] IRQ_MODE = 3'd2;
    localparam logic [2:0] IRQ_POL  = 3'd3;
    localparam logic [2:0] IRQ_SET  = 3'd4;
    localparam logic [2:0] IRQ_CTRL = 3'd5;
    localparam logic [2:0] IRQ_VEC  = 3'd6;
    localparam logic [2:0] IRQ_RSVD = 3'd7;

endpackage

// File: rtl/prio_enc.sv
// Priority encoder: index of the highest set request bit, 0 when none is set.
module prio_enc #(
    parameter int VBITS = 4
) (
    input  logic [2**VBITS-1:0] req,
    output logic [VBITS-1:0]    idx
);

    // Bit 0 is the "no request" vector, so it maps to index 0 like an empty input.
    always_comb begin
        idx = '0;
        for (int i = 0; i < 2**VBITS; i++) begin
            if (req[i]) begin
                idx = VBITS'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-channel edge/level conditioning, pending/enable registers,
// CPU register access and the irq/ivec/iack handshake.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int WIDTH    = IRQ_WIDTH,
    parameter int CHANNELS = IRQ_CHANNELS,
    parameter int VBITS    = IRQ_VBITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] src,
    input  logic                io_rd,
    input  logic                io_wr,
    input  logic [2:0]          io_addr,
    input  logic [WIDTH-1:0]    din,
    output logic [WIDTH-1:0]    io_dout,
    output logic                irq,
    output logic [VBITS-1:0]    ivec,
    input  logic                iack
);

    localparam int NVEC = 2 ** VBITS;

    logic [CHANNELS-1:0] pend_q;
    logic [CHANNELS-1:0] ena_q;
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] pol_q;
    logic [CHANNELS-1:0] prev_q;
    logic                ctrl_q;

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] e;
    logic [CHANNELS-1:0] pend_nxt;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] iack_hit;
    logic [NVEC-1:0]     req_ext;

    logic wr_pend;
    logic wr_ena;
    logic wr_mode;
    logic wr_pol;
    logic wr_set;
    logic wr_ctrl;

    // Reads have no side effects, and din bits above the channel count are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{io_rd, din};

    assign s = src ^ pol_q;
    assign e = s & ~prev_q;

    assign wr_pend = io_wr && (io_addr == IRQ_PEND);
    assign wr_ena  = io_wr && (io_addr == IRQ_ENA);
    assign wr_mode = io_wr && (io_addr == IRQ_MODE);
    assign wr_pol  = io_wr && (io_addr == IRQ_POL);
    assign wr_set  = io_wr && (io_addr == IRQ_SET);
    assign wr_ctrl = io_wr && (io_addr == IRQ_CTRL);

    // Gating with rst keeps irq/ivec low for the whole reset window, not just after its first edge.
    assign req     = (rst || !ctrl_q) ? '0 : (pend_q & ena_q);
    assign req_ext = NVEC'({req, 1'b0});

    prio_enc #(
        .VBITS (VBITS)
    ) u_prio_enc (
        .req (req_ext),
        .idx (ivec)
    );

    assign irq = (ivec != '0);

    for (genvar c = 1; c <= CHANNELS; c++) begin : g_ch
        assign iack_hit[c-1] = iack && (ivec == VBITS'(c));

        // Edge channels: a new set beats any clear in the same cycle so no event is lost.
        assign pend_nxt[c-1] =
            !mode_q[c-1]                              ? s[c-1] :
            (e[c-1] || (wr_set && din[c-1]))          ? 1'b1   :
            ((wr_pend && din[c-1]) || iack_hit[c-1])  ? 1'b0   :
                                                        pend_q[c-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            ena_q  <= '0;
            mode_q <= '1;
            pol_q  <= '0;
            ctrl_q <= 1'b0;
            prev_q <= src;
        end else begin
            pend_q <= pend_nxt;
            prev_q <= s;
            if (wr_ena) begin
                ena_q <= din[CHANNELS-1:0];
            end
            if (wr_mode) begin
                mode_q <= din[CHANNELS-1:0];
            end
            if (wr_pol) begin
                pol_q <= din[CHANNELS-1:0];
            end
            if (wr_ctrl) begin
                ctrl_q <= din[0];
            end
        end
    end

    always_comb begin
        io_dout = '0;
        case (io_addr)
            IRQ_PEND: io_dout = WIDTH'(pend_q);
            IRQ_ENA:  io_dout = WIDTH'(ena_q);
            IRQ_MODE: io_dout = WIDTH'(mode_q);
            IRQ_POL:  io_dout = WIDTH'(pol_q);
            IRQ_CTRL: io_dout = WIDTH'(ctrl_q);
            IRQ_VEC:  io_dout = WIDTH'(ivec);
            default:  io_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each register read pushes its expected dout/irq/ivec,
// and a monitor compares them whenever a read strobe is presented.
module tb_irq_ctrl;

    localparam int WIDTH    = 18;
    localparam int CHANNELS = 15;
    localparam int VBITS    = 4;

    localparam logic [2:0] A_PEND = 3'd0;
    localparam logic [2:0] A_ENA  = 3'd1;
    localparam logic [2:0] A_MODE = 3'd2;
    localparam logic [2:0] A_POL  = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CTRL = 3'd5;
    localparam logic [2:0] A_VEC  = 3'd6;
    localparam logic [2:0] A_RSVD = 3'd7;

    logic                clk = 1'b0;
    logic                rst;
    logic [CHANNELS-1:0] src;
    logic                io_rd;
    logic                io_wr;
    logic [2:0]          io_addr;
    logic [WIDTH-1:0]    din;
    logic [WIDTH-1:0]    io_dout;
    logic                irq;
    logic [VBITS-1:0]    ivec;
    logic                iack;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] dout;
        logic             irq;
        logic [VBITS-1:0] ivec;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    irq_ctrl #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .VBITS    (VBITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .din     (din),
        .io_dout (io_dout),
        .irq     (irq),
        .ivec    (ivec),
        .iack    (iack)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (io_rd) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: dout %h with no expectation queued", io_dout);
                end else begin
                    cur = sb.pop_front();
                    checks += 3;
                    if (io_dout !== cur.dout) begin
                        errors++;
                        $display("FAIL %s dout: got %h want %h", cur.name, io_dout, cur.dout);
                    end
                    if (irq !== cur.irq) begin
                        errors++;
                        $display("FAIL %s irq: got %0b want %0b", cur.name, irq, cur.irq);
                    end
                    if (ivec !== cur.ivec) begin
                        errors++;
                        $display("FAIL %s ivec: got %0d want %0d", cur.name, ivec, cur.ivec);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
        io_wr   = 1'b1;
        io_addr = a;
        din     = d;
        tick();
        io_wr = 1'b0;
        din   = '0;
    endtask

    task automatic expect_rd(input string n, input logic [WIDTH-1:0] d,
                             input logic i, input logic [VBITS-1:0] v);
        exp_t x;
        x.name = n;
        x.dout = d;
        x.irq  = i;
        x.ivec = v;
        sb.push_back(x);
    endtask

    task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] d,
                      input logic i, input logic [VBITS-1:0] v, input string n);
        expect_rd(n, d, i, v);
        io_rd   = 1'b1;
        io_addr = a;
        @(negedge clk);
        tick();
        io_rd = 1'b0;
    endtask

    task automatic ack();
        iack = 1'b1;
        tick();
        iack = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        src     = '0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_addr = '0;
        din     = '0;
        iack    = 1'b0;
        tick();

        // Reset state and single edge channel with acknowledge
        do_reset();
        rd(A_PEND, 18'h0,    1'b0, 4'd0, "rst_pend");
        rd(A_MODE, 18'h7FFF, 1'b0, 4'd0, "rst_mode");
        rd(A_ENA,  18'h0,    1'b0, 4'd0, "rst_ena");
        rd(A_CTRL, 18'h0,    1'b0, 4'd0, "rst_ctrl");
        rd(A_RSVD, 18'h0,    1'b0, 4'd0, "rsvd_read");
        wr(A_ENA, 18'h0002);
        wr(A_CTRL, 18'h1);
        src = 15'h0002;
        tick();
        rd(A_PEND, 18'h0002, 1'b1, 4'd2, "t1_pend");
        src  = '0;
        ack();
        rd(A_PEND, 18'h0,    1'b0, 4'd0, "t1_acked");

        // Priority order across three simultaneous edges
        do_reset();
        wr(A_ENA, 18'h7FFF);
        wr(A_CTRL, 18'h1);
        src = 15'h4104;
        tick();
        rd(A_VEC, 18'd15, 1'b1, 4'd15, "t2_vec15");
        ack();
        rd(A_VEC, 18'd9,  1'b1, 4'd9,  "t2_vec9");
        ack();
        rd(A_VEC, 18'd3,  1'b1, 4'd3,  "t2_vec3");
        ack();
        rd(A_VEC, 18'd0,  1'b0, 4'd0,  "t2_vec0");
        src = '0;

        // Level channel ignores iack and W1C
        do_reset();
        wr(A_MODE, 18'h7FEF);
        wr(A_ENA, 18'h0010);
        wr(A_CTRL, 18'h1);
        src = 15'h0010;
        tick();
        rd(A_VEC, 18'd5, 1'b1, 4'd5, "t3_level");
        wr(A_PEND, 18'h0010);
        rd(A_PEND, 18'h0010, 1'b1, 4'd5, "t3_w1c_ignored");
        ack();
        rd(A_VEC, 18'd5, 1'b1, 4'd5, "t3_iack_ignored");
        src = '0;
        tick();
        rd(A_PEND, 18'h0, 1'b0, 4'd0, "t3_released");

        // New edge coincident with iack of the same channel
        do_reset();
        wr(A_ENA, 18'h0001);
        wr(A_CTRL, 18'h1);
        src = 15'h0001;
        tick();
        src = '0;
        tick();
        rd(A_VEC, 18'd1, 1'b1, 4'd1, "t4_pending");
        src = 15'h0001;
        ack();
        rd(A_PEND, 18'h0001, 1'b1, 4'd1, "t4_set_wins");
        src = '0;

        // Active-low channel high through reset, masked pending, W1C
        src = 15'h0001;
        do_reset();
        rd(A_PEND, 18'h0, 1'b0, 4'd0, "t5_no_spurious");
        wr(A_POL, 18'h0001);
        rd(A_PEND, 18'h0, 1'b0, 4'd0, "t5_pol_flip");
        wr(A_CTRL, 18'h1);
        src = '0;
        tick();
        rd(A_PEND, 18'h0001, 1'b0, 4'd0, "t5_masked_pend");
        rd(A_POL,  18'h0001, 1'b0, 4'd0, "t5_pol_read");
        wr(A_PEND, 18'h0001);
        rd(A_PEND, 18'h0, 1'b0, 4'd0, "t5_w1c");

        // Software set, global enable gate, reset mid-operation
        do_reset();
        wr(A_ENA, 18'h0040);
        wr(A_SET, 18'h0040);
        rd(A_PEND, 18'h0040, 1'b0, 4'd0, "t6_set_gated");
        rd(A_SET,  18'h0,    1'b0, 4'd0, "t6_set_reads0");
        wr(A_CTRL, 18'h1);
        rd(A_VEC,  18'd7, 1'b1, 4'd7, "t6_vec7");
        rd(A_CTRL, 18'h1, 1'b1, 4'd7, "t6_ctrl");
        rst = 1'b1;
        tick();
        rd(A_PEND, 18'h0, 1'b0, 4'd0, "t6_rst_clears");
        rst = 1'b0;
        rd(A_MODE, 18'h7FFF, 1'b0, 4'd0, "t6_rst_mode");

        // SET has no effect on a level channel
        wr(A_MODE, 18'h7FFE);
        wr(A_ENA, 18'h0001);
        wr(A_CTRL, 18'h1);
        wr(A_SET, 18'h0001);
        rd(A_PEND, 18'h0, 1'b0, 4'd0, "level_set_ignored");

        // Simultaneous read and write returns the old value; unused din bits dropped
        expect_rd("rdwr_old", 18'h0001, 1'b0, 4'd0);
        io_rd   = 1'b1;
        io_wr   = 1'b1;
        io_addr = A_ENA;
        din     = 18'h2A5A;
        @(negedge clk);
        tick();
        io_rd = 1'b0;
        io_wr = 1'b0;
        rd(A_ENA, 18'h2A5A, 1'b0, 4'd0, "rdwr_new");
        wr(A_ENA, 18'h3FFFF);
        rd(A_ENA, 18'h7FFF, 1'b0, 4'd0, "ena_width");

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
